// File: rtl/sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : sprite_animator
// Purpose  : Steps a 16-pixel sprite across the screen at a fixed frame rate.
//            A free-running tick counter paces steps; each step issues one
//            draw request to a downstream sprite drawer and, once the drawer
//            reports completion, advances x position and animation frame.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_animator #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int FRAME_RATE = 10,
    parameter int X_START    = 0,
    parameter int X_STEP     = 4,
    parameter int X_MAX      = 224,
    parameter int Y_POS      = 160,
    parameter int FRAME_BASE = 0,
    parameter int NUM_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        drawReady,
    output logic        draw,
    output logic [7:0]  xOrigin,
    output logic [8:0]  yOrigin,
    output logic [7:0]  mifId,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frameCount
);

    localparam int c_tick_period = CLOCK_FREQ / FRAME_RATE;
    localparam int c_cnt_w       = (c_tick_period > 1) ? $clog2(c_tick_period) : 1;
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(c_tick_period - 1);

    localparam logic [8:0] c_x_step     = 9'(X_STEP);
    localparam logic [8:0] c_x_max      = 9'(X_MAX);
    localparam logic [7:0] c_x_start    = 8'(X_START);
    localparam logic [7:0] c_frame_last = 8'(NUM_FRAMES - 1);
    localparam logic [7:0] c_frame_base = 8'(FRAME_BASE);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_request   = 2'd1;
    localparam logic [1:0] c_st_wait_done = 2'd2;
    localparam logic [1:0] c_st_advance   = 2'd3;

    logic [c_cnt_w-1:0] r_tick_cnt;
    logic               w_tick;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [7:0]         r_x;
    logic [7:0]         r_frame_idx;
    logic [15:0]        r_frame_count;
    logic               r_overrun;
    logic [8:0]         w_x_sum;

    assign w_tick = (r_tick_cnt == c_tick_last);

    // Free-running step pacer; wraps to zero in the tick cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one draw handshake per accepted tick
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_tick && enable && drawReady) begin
                    w_state_next = c_st_request;
                end
            end
            c_st_request: begin
                // drawReady going low means the drawer has taken the request
                if (!drawReady) begin
                    w_state_next = c_st_wait_done;
                end
            end
            c_st_wait_done: begin
                if (drawReady) begin
                    w_state_next = c_st_advance;
                end
            end
            c_st_advance: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Sticky overrun: a tick that could not start a draw is lost for good
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_tick && ((r_state != c_st_idle) || (enable && !drawReady))) begin
            r_overrun <= 1'b1;
        end
    end

    // Carry kept so a step past 255 is still seen as beyond X_MAX
    assign w_x_sum = {1'b0, r_x} + c_x_step;

    // Position, frame and completed-draw count move only in ADVANCE
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x           <= c_x_start;
            r_frame_idx   <= '0;
            r_frame_count <= '0;
        end else if (r_state == c_st_advance) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_x           <= (w_x_sum > c_x_max) ? c_x_start : w_x_sum[7:0];
            r_frame_idx   <= (r_frame_idx == c_frame_last) ? 8'd0 : r_frame_idx + 8'd1;
        end
    end

    assign draw       = (r_state == c_st_request);
    assign busy       = (r_state != c_st_idle);
    assign overrun    = r_overrun;
    assign frameCount = r_frame_count;
    assign xOrigin    = r_x;
    assign yOrigin    = 9'(Y_POS);
    assign mifId      = c_frame_base + r_frame_idx;

endmodule
`default_nettype wire

// File: tb/tb_sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_animator
// Purpose  : Self-checking bench for sprite_animator with a 10-cycle tick.
//            Per-cycle vector table for handshake, overrun, enable and reset
//            cases, then a drawer loop stepping x through its wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_animator;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        drawReady;
    logic        draw;
    logic [7:0]  xOrigin;
    logic [8:0]  yOrigin;
    logic [7:0]  mifId;
    logic        busy;
    logic        overrun;
    logic [15:0] frameCount;

    int checks;
    int errors;

    sprite_animator #(
        .CLOCK_FREQ (100),
        .FRAME_RATE (10),
        .X_START    (0),
        .X_STEP     (4),
        .X_MAX      (224),
        .Y_POS      (160),
        .FRAME_BASE (0),
        .NUM_FRAMES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .drawReady  (drawReady),
        .draw       (draw),
        .xOrigin    (xOrigin),
        .yOrigin    (yOrigin),
        .mifId      (mifId),
        .busy       (busy),
        .overrun    (overrun),
        .frameCount (frameCount)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic        dr;
        int          n;
        logic        d;
        logic        b;
        logic [7:0]  x;
        logic [7:0]  m;
        logic        ov;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic dr, input int n,
                       input logic d, input logic b, input logic [7:0] x,
                       input logic [7:0] m, input logic ov, input logic [15:0] fc);
        vecs.push_back('{rst, en, dr, n, d, b, x, m, ov, fc});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        int   exp_x;
        int   c;
        logic got;

        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        drawReady = 1'b1;

        //  rst en dr  n   draw busy  x     mif   ov  fc
        add(1, 1, 1,  1,  0, 0, 8'd0, 8'd0, 0, 16'd0);  // E0 reset
        add(0, 1, 1,  9,  0, 0, 8'd0, 8'd0, 0, 16'd0);  // E1-9 idle
        add(0, 1, 1,  3,  1, 1, 8'd0, 8'd0, 0, 16'd0);  // E10-12 draw rises at 10
        add(0, 1, 0,  5,  0, 1, 8'd0, 8'd0, 0, 16'd0);  // E13-17 wait done
        add(0, 1, 1,  1,  0, 1, 8'd0, 8'd0, 0, 16'd0);  // E18 advance
        add(0, 1, 1,  1,  0, 0, 8'd4, 8'd1, 0, 16'd1);  // E19 idle, stepped
        add(0, 1, 1,  1,  1, 1, 8'd4, 8'd1, 0, 16'd1);  // E20 second draw
        add(0, 1, 1,  9,  1, 1, 8'd4, 8'd1, 0, 16'd1);  // E21-29 drawer stalls
        add(0, 1, 1,  5,  1, 1, 8'd4, 8'd1, 1, 16'd1);  // E30-34 tick dropped
        add(0, 1, 0,  2,  0, 1, 8'd4, 8'd1, 1, 16'd1);  // E35-36 wait done
        add(0, 1, 1,  1,  0, 1, 8'd4, 8'd1, 1, 16'd1);  // E37 advance
        add(0, 1, 1,  2,  0, 0, 8'd8, 8'd0, 1, 16'd2);  // E38-39 idle, sticky
        add(0, 1, 1,  2,  1, 1, 8'd8, 8'd0, 1, 16'd2);  // E40-41 third draw
        add(0, 1, 0,  1,  0, 1, 8'd8, 8'd0, 1, 16'd2);  // E42 wait done
        add(1, 1, 0,  1,  0, 0, 8'd0, 8'd0, 0, 16'd0);  // E43 reset in wait
        add(0, 0, 1, 25,  0, 0, 8'd0, 8'd0, 0, 16'd0);  // E44-68 ticks ignored
        add(0, 0, 1,  4,  0, 0, 8'd0, 8'd0, 0, 16'd0);  // E69-72 idle
        add(0, 1, 1,  1,  1, 1, 8'd0, 8'd0, 0, 16'd0);  // E73 draw
        add(0, 0, 1,  2,  1, 1, 8'd0, 8'd0, 0, 16'd0);  // E74-75 enable dropped
        add(0, 0, 0,  2,  0, 1, 8'd0, 8'd0, 0, 16'd0);  // E76-77 wait done
        add(0, 0, 1,  1,  0, 1, 8'd0, 8'd0, 0, 16'd0);  // E78 advance
        add(0, 0, 1,  1,  0, 0, 8'd4, 8'd1, 0, 16'd1);  // E79 completed
        add(0, 1, 0,  3,  0, 0, 8'd4, 8'd1, 0, 16'd1);  // E80-82 drawer busy
        add(0, 1, 0,  1,  0, 0, 8'd4, 8'd1, 1, 16'd1);  // E83 tick in idle lost

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge clock);
                reset     = vecs[i].rst;
                enable    = vecs[i].en;
                drawReady = vecs[i].dr;
                @(posedge clock);
                #1;
                chk($sformatf("row%0d.%0d draw", i, k), 32'(draw), 32'(vecs[i].d));
                chk($sformatf("row%0d.%0d busy", i, k), 32'(busy), 32'(vecs[i].b));
                chk($sformatf("row%0d.%0d xOrigin", i, k), 32'(xOrigin), 32'(vecs[i].x));
                chk($sformatf("row%0d.%0d mifId", i, k), 32'(mifId), 32'(vecs[i].m));
                chk($sformatf("row%0d.%0d overrun", i, k), 32'(overrun), 32'(vecs[i].ov));
                chk($sformatf("row%0d.%0d frameCount", i, k), 32'(frameCount), 32'(vecs[i].fc));
                chk($sformatf("row%0d.%0d yOrigin", i, k), 32'(yOrigin), 32'd160);
            end
        end

        // Prompt drawer: 58 steps walk x 0..224 and wrap back to 0
        @(negedge clock);
        reset     = 1'b1;
        enable    = 1'b1;
        drawReady = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_x = 0;
        for (int s = 0; s < 58; s++) begin
            got = 1'b0;
            for (c = 0; c < 20; c++) begin
                if (draw) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            chk($sformatf("step%0d draw_seen", s), 32'(got), 32'd1);
            if (!got) break;
            chk($sformatf("step%0d xOrigin", s), 32'(xOrigin), 32'(exp_x));
            chk($sformatf("step%0d mifId", s), 32'(mifId), 32'(s % 2));
            drawReady = 1'b0;
            @(negedge clock);
            chk($sformatf("step%0d draw_low", s), 32'(draw), 32'd0);
            drawReady = 1'b1;
            got = 1'b0;
            for (c = 0; c < 10; c++) begin
                @(negedge clock);
                if (!busy) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("step%0d idle_seen", s), 32'(got), 32'd1);
            chk($sformatf("step%0d frameCount", s), 32'(frameCount), 32'(s + 1));
            exp_x = (exp_x + 4 > 224) ? 0 : exp_x + 4;
        end
        chk("wrap xOrigin", 32'(xOrigin), 32'(exp_x));
        chk("wrap overrun", 32'(overrun), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FRAME_RATE, default 10, animation steps per second.
REQ-003 SHALL have parameter X_START, default 0, first and wrap-to x position.
REQ-004 SHALL have parameter X_STEP, default 4, x increment per step.
REQ-005 SHALL have parameter X_MAX, default 224, largest legal x origin (240 minus 16-pixel sprite width).
REQ-006 SHALL have parameter Y_POS, default 160, fixed y origin.
REQ-007 SHALL have parameter FRAME_BASE, default 0, mifId of first animation frame.
REQ-008 SHALL have parameter NUM_FRAMES, default 2, animation frames cycled (1..255).
REQ-009 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-010 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-011 SHALL have port enable  input  1  permits new draw requests when high.
REQ-012 SHALL have port drawReady  input  1  ready flag from downstream sprite drawer.
REQ-013 SHALL have port draw  output  1  draw request to downstream drawer.
REQ-014 SHALL have port xOrigin  output  8  sprite x origin.
REQ-015 SHALL have port yOrigin  output  9  sprite y origin.
REQ-016 SHALL have port mifId  output  8  sprite image selector.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port overrun  output  1  sticky flag: a tick was dropped.
REQ-019 SHALL have port frameCount  output  16  count of completed draws.

Function
REQ-020 Tick counter SHALL count 0..TICK_PERIOD-1 continuously, TICK_PERIOD = CLOCK_FREQ/FRAME_RATE, and SHALL emit a one-cycle internal tick in the cycle it holds TICK_PERIOD-1, then return to 0.
REQ-021 State machine SHALL have states IDLE, REQUEST, WAIT_DONE, ADVANCE.
REQ-022 IDLE: on tick with enable=1 and drawReady=1, SHALL go to REQUEST; draw high the following cycle (1-cycle latency from tick).
REQ-023 IDLE: tick with enable=1 and drawReady=0 SHALL set overrun and stay in IDLE; tick with enable=0 SHALL be ignored without setting overrun.
REQ-024 REQUEST: draw SHALL stay high until drawReady is sampled 0, then go to WAIT_DONE with draw low the next cycle.
REQ-025 WAIT_DONE: draw SHALL be low; on drawReady sampled 1, go to ADVANCE.
REQ-026 ADVANCE (one cycle): SHALL increment frameCount (wraps 0xFFFF->0), advance frame index, update xOrigin, return to IDLE.
REQ-027 Next x SHALL be computed 9 bits wide as xOrigin+X_STEP; if result > X_MAX, xOrigin SHALL become X_START, else the result.
REQ-028 Frame index SHALL wrap NUM_FRAMES-1 -> 0; mifId SHALL equal FRAME_BASE + frame index.
REQ-029 xOrigin, yOrigin, mifId SHALL change only in ADVANCE (or reset), stable through REQUEST and WAIT_DONE.
REQ-030 Tick arriving in REQUEST, WAIT_DONE or ADVANCE SHALL be dropped and SHALL set overrun; no queued request.
REQ-031 overrun SHALL clear only on reset.
REQ-032 enable falling mid-transaction SHALL NOT abort it; the in-flight draw completes through ADVANCE.
REQ-033 yOrigin SHALL always equal Y_POS.

Reset
REQ-034 reset high at a rising edge SHALL force state IDLE, draw=0, busy=0, overrun=0, frameCount=0, tick counter=0, frame index=0, xOrigin=X_START, yOrigin=Y_POS, mifId=FRAME_BASE.
REQ-035 reset mid-transaction SHALL take effect on the same edge; draw low the next cycle, no ADVANCE performed.

Verification (CLOCK_FREQ=100, FRAME_RATE=10, TICK_PERIOD=10)
REQ-036 Reset release, enable=1, drawReady=1 -> draw rises at cycle 10 with xOrigin=0, mifId=0, yOrigin=160.
REQ-037 Drawer model drops drawReady 2 cycles after draw, raises it 5 cycles later -> draw falls 1 cycle after drawReady falls; next step xOrigin=4, mifId=1, frameCount=1.
REQ-038 Run 57 steps -> xOrigin sequence reaches 224 then wraps to 0; mifId alternates 0,1.
REQ-039 Drawer holds drawReady=1 after draw for 15 cycles -> draw held high, tick dropped, overrun=1 and stays 1.
REQ-040 enable=0 across two ticks -> no draw, overrun=0; enable dropped during REQUEST -> transaction still completes, frameCount increments.
REQ-041 reset asserted during WAIT_DONE -> all outputs at REQ-034 values next cycle, frameCount=0.
